// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: stall/flush strobes, PC write/redirect,
// halt tracking and saturating performance counters.
module hazard_control_unit #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           rs_ID,
    input  logic [1:0]           rt_ID,
    input  logic                 uses_rs_ID,
    input  logic                 uses_rt_ID,
    input  logic [1:0]           dest_EX,
    input  logic                 RegWrite_EX,
    input  logic                 d_readM_EX,
    input  logic                 mispredict_EX,
    input  logic [WORD_SIZE-1:0] actual_pc_EX,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ready,
    input  logic                 d_mem_req,
    input  logic                 d_mem_ready,
    input  logic                 is_halted_WB,
    output logic                 pc_write,
    output logic                 redirect_en,
    output logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 stall_IF_ID,
    output logic                 stall_ID_EX,
    output logic                 stall_EX_MEM,
    output logic                 flush_IF_ID,
    output logic                 flush_ID_EX,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        IWAIT  = 2'd1,
        DWAIT  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t               state, state_nx, eff;
    logic                 pend, pend_nx;
    logic [WORD_SIZE-1:0] pend_pc, pend_pc_nx;
    logic                 flush_inc;
    logic                 load_use, i_wait, d_wait;

    assign load_use = d_readM_EX & RegWrite_EX &
                      ((uses_rs_ID & (rs_ID == dest_EX)) |
                       (uses_rt_ID & (rt_ID == dest_EX)));
    assign i_wait   = i_mem_req & ~i_mem_ready;
    assign d_wait   = d_mem_req & ~d_mem_ready;

    // A completing data wait is handled exactly like RUN in the same cycle.
    assign eff = (state == DWAIT && d_mem_ready) ? RUN : state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            pend         <= 1'b0;
            pend_pc      <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            pend_pc <= pend_pc_nx;
            if (state != HALTED && !pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

    always_comb begin
        state_nx   = eff;
        pend_nx    = pend;
        pend_pc_nx = pend_pc;
        flush_inc  = 1'b0;
        unique case (eff)
            RUN: begin
                if (is_halted_WB) begin
                    state_nx = HALTED;
                end else if (d_wait) begin
                    state_nx = DWAIT;
                end else if (mispredict_EX) begin
                    flush_inc = 1'b1;
                    if (i_wait) begin
                        pend_nx    = 1'b1;
                        pend_pc_nx = actual_pc_EX;
                        state_nx   = IWAIT;
                    end
                end else if (!load_use && i_wait) begin
                    state_nx = IWAIT;
                end
            end
            IWAIT: begin
                // The fetch is only retired when IF/ID is free to take it.
                if (is_halted_WB) begin
                    state_nx = HALTED;
                    pend_nx  = 1'b0;
                end else if (d_wait) begin
                    state_nx = IWAIT;
                end else if (mispredict_EX) begin
                    flush_inc = 1'b1;
                    if (i_mem_ready) begin
                        state_nx = RUN;
                        pend_nx  = 1'b0;
                    end else begin
                        pend_nx    = 1'b1;
                        pend_pc_nx = actual_pc_EX;
                    end
                end else if (!load_use && i_mem_ready) begin
                    state_nx = RUN;
                    pend_nx  = 1'b0;
                end
            end
            DWAIT:  state_nx = DWAIT;
            HALTED: state_nx = HALTED;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        redirect_en  = 1'b0;
        redirect_pc  = pend_pc;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        halted       = (state == HALTED);
        unique case (eff)
            RUN: begin
                if (is_halted_WB || d_wait) begin
                    {stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 3'b111;
                end else if (mispredict_EX) begin
                    pc_write    = 1'b1;
                    redirect_en = 1'b1;
                    redirect_pc = actual_pc_EX;
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (load_use) begin
                    stall_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (i_wait) begin
                    flush_IF_ID = 1'b1;
                end else begin
                    pc_write = 1'b1;
                end
            end
            IWAIT: begin
                if (is_halted_WB || d_wait) begin
                    {stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 3'b111;
                end else if (mispredict_EX) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    if (i_mem_ready) begin
                        pc_write    = 1'b1;
                        redirect_en = 1'b1;
                        redirect_pc = actual_pc_EX;
                    end
                end else if (load_use) begin
                    stall_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (i_mem_ready) begin
                    pc_write    = 1'b1;
                    redirect_en = pend;
                    flush_IF_ID = pend;
                end else begin
                    flush_IF_ID = 1'b1;
                end
            end
            DWAIT, HALTED: begin
                {stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 3'b111;
            end
        endcase
        if (!reset_n) begin
            pc_write     = 1'b0;
            redirect_en  = 1'b0;
            stall_IF_ID  = 1'b0;
            stall_ID_EX  = 1'b0;
            stall_EX_MEM = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            halted       = 1'b0;
        end
    end

endmodule
